// File: rtl/fft_digit_reverse_reorder.sv
// Ping-pong reorder buffer for the radix-4 FFT output: writes each frame at base-4
// digit-reversed addresses into one bank while reading the other bank linearly.
module fft_digit_reverse_reorder #(
  parameter int WORDLENGTH_IO = 16,
  parameter int LOG4N         = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [2*WORDLENGTH_IO-1:0]   data_in,
  output logic [2*WORDLENGTH_IO-1:0]   data_out,
  output logic                         out_valid,
  output logic                         out_sop
);
  localparam int AW = 2*LOG4N;
  localparam int N  = 1 << AW;
  localparam int DW = 2*WORDLENGTH_IO;

  logic [AW-1:0] wcnt_q, wcnt_d, wrev;
  logic          wbank_q, wbank_d;
  logic          primed_q, primed_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          valid_q, valid_d;
  logic          sop_q, sop_d;
  logic          wrap;

  // Bank select is the address MSB: {bank, word}.
  logic [DW-1:0] mem_q [2*N];

  // Base-4 digit reversal: whole bit pairs swap, bits within a pair keep their order.
  for (genvar d = 0; d < LOG4N; d++) begin : g_rev
    assign wrev[2*d +: 2] = wcnt_q[2*(LOG4N-1-d) +: 2];
  end

  assign wrap = (wcnt_q == '1);

  always_comb begin
    wcnt_d   = wcnt_q;
    wbank_d  = wbank_q;
    primed_d = primed_q;
    dout_d   = dout_q;
    valid_d  = 1'b0;
    sop_d    = 1'b0;
    if (enable) begin
      wcnt_d  = wcnt_q + AW'(1);
      valid_d = primed_q;
      sop_d   = primed_q && (wcnt_q == '0);
      // Until a full frame exists the read bank holds garbage; keep data_out at zero.
      if (primed_q) dout_d = mem_q[{~wbank_q, wcnt_q}];
      if (wrap) begin
        wbank_d  = ~wbank_q;
        primed_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt_q   <= '0;
      wbank_q  <= 1'b0;
      primed_q <= 1'b0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      sop_q    <= 1'b0;
    end else begin
      wcnt_q   <= wcnt_d;
      wbank_q  <= wbank_d;
      primed_q <= primed_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      sop_q    <= sop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enable) mem_q[{wbank_q, wrev}] <= data_in;
  end

  assign data_out  = dout_q;
  assign out_valid = valid_q;
  assign out_sop   = sop_q;
endmodule

// File: tb/tb_fft_digit_reverse_reorder.sv
// Directed bench: N=64 ordering, priming, back-to-back frames, stall, mid-run reset,
// plus an N=4 / 8-bit instance where the digit reversal is the identity.
module tb_fft_digit_reverse_reorder;
  logic        clk = 1'b0;
  logic        rst;
  logic        en, en4;
  logic [31:0] din, dout;
  logic        val, sop;
  logic [15:0] din4, dout4;
  logic        val4, sop4;

  int          tests = 0;
  int          fails = 0;
  int          c = 0;
  int          c4 = 0;
  logic [31:0] exp_d = '0;
  logic [15:0] exp4 = '0;

  always #5 clk = ~clk;

  fft_digit_reverse_reorder #(.WORDLENGTH_IO(16), .LOG4N(3)) dut (
    .clk(clk), .rst(rst), .enable(en), .data_in(din),
    .data_out(dout), .out_valid(val), .out_sop(sop)
  );

  fft_digit_reverse_reorder #(.WORDLENGTH_IO(8), .LOG4N(1)) dut4 (
    .clk(clk), .rst(rst), .enable(en4), .data_in(din4),
    .data_out(dout4), .out_valid(val4), .out_sop(sop4)
  );

  function automatic int rev3(int k);
    return ((k & 3) << 4) | (k & 12) | ((k >> 4) & 3);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, obs, expv);
    end
  endtask

  // One clock on the N=64 instance; the expected output follows the frame/bin arithmetic.
  task automatic step(bit e);
    int v;
    bit ev, es;
    en  = e;
    din = e ? {c[15:0], c[15:0]} : 32'hDEAD_BEEF;
    @(posedge clk); #1;
    ev = 1'b0;
    es = 1'b0;
    if (e) begin
      ev = (c >= 64);
      es = ev && (c % 64 == 0);
      if (ev) begin
        v     = (c / 64 - 1) * 64 + rev3(c % 64);
        exp_d = {v[15:0], v[15:0]};
      end
      c++;
    end
    chk("out_valid", 32'(val), 32'(ev));
    chk("out_sop",   32'(sop), 32'(es));
    chk("data_out",  dout, exp_d);
  endtask

  task automatic step4();
    int v;
    bit ev, es;
    en4  = 1'b1;
    din4 = {c4[7:0], c4[7:0]};
    @(posedge clk); #1;
    ev = (c4 >= 4);
    es = ev && (c4 % 4 == 0);
    if (ev) begin
      v    = c4 - 4;
      exp4 = {v[7:0], v[7:0]};
    end
    c4++;
    chk("n4_valid", 32'(val4), 32'(ev));
    chk("n4_sop",   32'(sop4), 32'(es));
    chk("n4_data",  32'(dout4), 32'(exp4));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; en = 1'b0; en4 = 1'b0; din = '0; din4 = '0;
    #3;
    chk("rst_valid", 32'(val), 32'd0);
    chk("rst_sop",   32'(sop), 32'd0);
    chk("rst_data",  dout, 32'd0);
    chk("rst_n4_valid", 32'(val4), 32'd0);
    chk("rst_n4_data",  32'(dout4), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Three frames of {c,c}; a 5-cycle stall right after bin 10 of the first output frame.
    for (int i = 0; i < 192; i++) begin
      step(1'b1);
      if (c == 75) repeat (5) step(1'b0);
    end

    // Reset, run to enabled cycle 100, then reset asynchronously mid-cycle.
    rst = 1'b0; #1;
    chk("rst2_valid", 32'(val), 32'd0);
    chk("rst2_data",  dout, 32'd0);
    rst = 1'b1;
    c = 0; exp_d = '0;
    repeat (100) step(1'b1);
    chk("pre_rst_valid", 32'(val), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_valid", 32'(val), 32'd0);
    chk("async_sop",   32'(sop), 32'd0);
    chk("async_data",  dout, 32'd0);
    en = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("held_rst_valid", 32'(val), 32'd0);
    chk("held_rst_data",  dout, 32'd0);
    rst = 1'b1;
    c = 0; exp_d = '0;
    repeat (72) step(1'b1);
    en = 1'b0;

    // Single-digit instance: identity order, wrap every 4 enabled cycles.
    repeat (16) step4();
    en4 = 1'b0;
    @(posedge clk); #1;
    chk("n4_stall_valid", 32'(val4), 32'd0);
    chk("n4_stall_data",  32'(dout4), 32'(exp4));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
